// File: rtl/machine_csr_unit.sv
// Machine-mode CSR file for the RV32 core: trap entry, mret, 64-bit counters, NUM_HPM
// hpmcounters, sampled interrupt pending detect, illegal-access flagging and M/U tracking.
// Optional feature: define CSR_VECTORED_MTVEC_EN to enable vectored mtvec mode.
module machine_csr_unit #(
    parameter logic [31:0] HART_ID = 32'd0,
    parameter int unsigned NUM_HPM = 4,
    parameter logic [31:0] MIMP_ID = 32'd2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               csr_re_i,
    input  logic [11:0]        csr_raddr_i,
    output logic [31:0]        csr_rdata_o,
    input  logic               csr_we_i,
    input  logic [11:0]        csr_waddr_i,
    input  logic [31:0]        csr_wdata_i,
    output logic               csr_illegal_o,
    input  logic               instr_ret_i,
    input  logic [NUM_HPM-1:0] hpm_event_i,
    input  logic               trap_i,
    input  logic               trap_irq_i,
    input  logic [4:0]         trap_cause_i,
    input  logic [31:0]        trap_pc_i,
    input  logic [31:0]        trap_val_i,
    input  logic               mret_i,
    input  logic               irq_ext_i,
    input  logic               irq_tmr_i,
    input  logic               irq_sw_i,
    output logic               irq_pending_o,
    output logic [31:0]        trap_target_o,
    output logic [31:0]        mret_target_o,
    output logic [1:0]         priv_lvl_o
);

    localparam logic [1:0]  PrivM = 2'b11;
    localparam logic [1:0]  PrivU = 2'b00;
    localparam logic [31:0] IrqMask = 32'h0000_0888;
    // Counter slots indexed by CSR address [4:0]: 0 cycle, 2 instret, 3.. hpm.
    localparam logic [31:0] CntMask =
        32'h0000_0005 | (32'((64'd1 << NUM_HPM) - 64'd1) << 3);

    logic [1:0]  priv_q, priv_d;
    logic        st_mie_q, st_mie_d;
    logic        st_mpie_q, st_mpie_d;
    logic [1:0]  st_mpp_q, st_mpp_d;
    logic        st_mprv_q, st_mprv_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mip_q, mip_d;
    logic [31:0] mcounteren_q, mcounteren_d;
    logic [31:0] mcountinhibit_q, mcountinhibit_d;
    logic        irq_pending_q, irq_pending_d;
    logic [63:0] cnt_q [32];
    logic [63:0] cnt_d [32];

    logic [31:0] mstatus_val;
    logic [31:0] rd_val;
    logic        rd_illegal;
    logic        wr_illegal;
    logic        wr_en;
    logic [31:0] cnt_ev;
    logic [31:0] trap_base;

    function automatic logic csr_impl(input logic [11:0] a);
        logic impl;
        impl = 1'b0;
        if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00) begin
            impl = CntMask[a[4:0]];
        end else if (a[11:5] == 7'h19 && a[4:0] >= 5'd3) begin
            impl = 1'b1; // mhpmevent3..31 read as zero
        end else begin
            case (a)
                12'h300, 12'h301, 12'h304, 12'h305, 12'h306, 12'h310, 12'h320,
                12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                12'hF11, 12'hF12, 12'hF13, 12'hF14: impl = 1'b1;
                default: impl = 1'b0;
            endcase
        end
        return impl;
    endfunction

    // Combinational read mux and access legality.
    always_comb begin
        mstatus_val     = '0;
        mstatus_val[3]  = st_mie_q;
        mstatus_val[7]  = st_mpie_q;
        mstatus_val[12:11] = st_mpp_q;
        mstatus_val[17] = st_mprv_q;
        rd_val = '0;
        if ((csr_raddr_i[11:8] == 4'hB || csr_raddr_i[11:8] == 4'hC)
            && csr_raddr_i[6:5] == 2'b00) begin
            rd_val = csr_raddr_i[7] ? cnt_q[csr_raddr_i[4:0]][63:32]
                                    : cnt_q[csr_raddr_i[4:0]][31:0];
        end else begin
            case (csr_raddr_i)
                12'h300: rd_val = mstatus_val;
                12'h301: rd_val = 32'h4000_0100;
                12'h304: rd_val = mie_q;
                12'h305: rd_val = mtvec_q;
                12'h306: rd_val = mcounteren_q;
                12'h320: rd_val = mcountinhibit_q;
                12'h340: rd_val = mscratch_q;
                12'h341: rd_val = mepc_q;
                12'h342: rd_val = mcause_q;
                12'h343: rd_val = mtval_q;
                12'h344: rd_val = mip_q;
                12'hF13: rd_val = MIMP_ID;
                12'hF14: rd_val = HART_ID;
                default: rd_val = '0;
            endcase
        end
        rd_illegal = !csr_impl(csr_raddr_i) || (csr_raddr_i[9:8] > priv_q)
                     || (priv_q == PrivU && csr_raddr_i[11:8] == 4'hC
                         && !mcounteren_q[csr_raddr_i[4:0]]);
        wr_illegal = !csr_impl(csr_waddr_i) || (csr_waddr_i[11:10] == 2'b11)
                     || (csr_waddr_i[9:8] > priv_q);
        wr_en         = csr_we_i && !wr_illegal;
        csr_illegal_o = (csr_re_i && rd_illegal) || (csr_we_i && wr_illegal);
        csr_rdata_o   = (csr_re_i && !rd_illegal) ? rd_val : '0;
    end

    // Trap redirect target from mtvec base, optionally vectored for interrupts.
    always_comb begin
        trap_base = {mtvec_q[31:2], 2'b00};
`ifdef CSR_VECTORED_MTVEC_EN
        trap_target_o = (mtvec_q[1:0] == 2'b01 && trap_irq_i)
                        ? trap_base + {25'd0, trap_cause_i, 2'b00} : trap_base;
`else
        trap_target_o = trap_base;
`endif
    end

    // Next-state: CSR writes first, then mret, then trap override the fields they own.
    always_comb begin
        priv_d          = priv_q;
        st_mie_d        = st_mie_q;
        st_mpie_d       = st_mpie_q;
        st_mpp_d        = st_mpp_q;
        st_mprv_d       = st_mprv_q;
        mtvec_d         = mtvec_q;
        mepc_d          = mepc_q;
        mcause_d        = mcause_q;
        mtval_d         = mtval_q;
        mscratch_d      = mscratch_q;
        mie_d           = mie_q;
        mcounteren_d    = mcounteren_q;
        mcountinhibit_d = mcountinhibit_q;
        mip_d           = '0;
        mip_d[11]       = irq_ext_i;
        mip_d[7]        = irq_tmr_i;
        mip_d[3]        = irq_sw_i;
        irq_pending_d   = (|(mip_q & mie_q & IrqMask)) && (st_mie_q || priv_q == PrivU);

        if (wr_en) begin
            case (csr_waddr_i)
                12'h300: begin
                    if (!trap_i && !mret_i) begin
                        st_mie_d  = csr_wdata_i[3];
                        st_mpie_d = csr_wdata_i[7];
                        st_mpp_d  = (csr_wdata_i[12:11] == PrivM) ? PrivM : PrivU;
                        st_mprv_d = csr_wdata_i[17];
                    end
                end
                12'h304: mie_d = csr_wdata_i & IrqMask;
`ifdef CSR_VECTORED_MTVEC_EN
                12'h305: mtvec_d = {csr_wdata_i[31:2],
                                    (csr_wdata_i[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
                12'h305: mtvec_d = {csr_wdata_i[31:2], 2'b00};
`endif
                12'h306: mcounteren_d    = csr_wdata_i & CntMask;
                12'h320: mcountinhibit_d = csr_wdata_i & CntMask;
                12'h340: mscratch_d      = csr_wdata_i;
                12'h341: if (!trap_i) mepc_d   = {csr_wdata_i[31:2], 2'b00};
                12'h342: if (!trap_i) mcause_d = csr_wdata_i;
                12'h343: if (!trap_i) mtval_d  = csr_wdata_i;
                default: ;
            endcase
        end

        if (trap_i) begin
            mepc_d    = {trap_pc_i[31:2], 2'b00};
            mcause_d  = {trap_irq_i, 26'd0, trap_cause_i};
            mtval_d   = trap_val_i;
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
            st_mpp_d  = priv_q;
            priv_d    = PrivM;
        end else if (mret_i) begin
            priv_d    = st_mpp_q;
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
            st_mpp_d  = PrivU;
            if (st_mpp_q != PrivM) st_mprv_d = 1'b0;
        end
    end

    // Counter increment with per-half write replacement; the unwritten half keeps the carry.
    always_comb begin
        cnt_ev = CntMask & ((32'(hpm_event_i) << 3) | {29'd0, instr_ret_i, 2'b01});
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = CntMask[i]
                       ? cnt_q[i] + {63'd0, cnt_ev[i] & ~mcountinhibit_q[i]} : '0;
            if (wr_en && csr_waddr_i[11:8] == 4'hB && csr_waddr_i[6:5] == 2'b00
                && csr_waddr_i[4:0] == 5'(i)) begin
                if (csr_waddr_i[7]) cnt_d[i][63:32] = csr_wdata_i;
                else                cnt_d[i][31:0]  = csr_wdata_i;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            priv_q          <= PrivM;
            st_mie_q        <= 1'b0;
            st_mpie_q       <= 1'b1;
            st_mpp_q        <= PrivU;
            st_mprv_q       <= 1'b0;
            mtvec_q         <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            mscratch_q      <= '0;
            mie_q           <= '0;
            mip_q           <= '0;
            mcounteren_q    <= '0;
            mcountinhibit_q <= '0;
            irq_pending_q   <= 1'b0;
            for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
        end else begin
            priv_q          <= priv_d;
            st_mie_q        <= st_mie_d;
            st_mpie_q       <= st_mpie_d;
            st_mpp_q        <= st_mpp_d;
            st_mprv_q       <= st_mprv_d;
            mtvec_q         <= mtvec_d;
            mepc_q          <= mepc_d;
            mcause_q        <= mcause_d;
            mtval_q         <= mtval_d;
            mscratch_q      <= mscratch_d;
            mie_q           <= mie_d;
            mip_q           <= mip_d;
            mcounteren_q    <= mcounteren_d;
            mcountinhibit_q <= mcountinhibit_d;
            irq_pending_q   <= irq_pending_d;
            for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign irq_pending_o = irq_pending_q;
    assign mret_target_o = mepc_q;
    assign priv_lvl_o    = priv_q;

endmodule

// File: tb/tb_machine_csr_unit.sv
// Directed bench for machine_csr_unit with a queue scoreboard of expected values.
`timescale 1ns/1ps
module tb_machine_csr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_re, csr_we;
    logic [11:0] csr_raddr, csr_waddr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        csr_illegal;
    logic        instr_ret;
    logic [3:0]  hpm_event;
    logic        trap, trap_irq, mret;
    logic [4:0]  trap_cause;
    logic [31:0] trap_pc, trap_val;
    logic        irq_ext, irq_tmr, irq_sw, irq_pending;
    logic [31:0] trap_target, mret_target;
    logic [1:0]  priv_lvl;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #50 clk = ~clk;

    machine_csr_unit #(
        .HART_ID(32'h0000_00A5),
        .NUM_HPM(4),
        .MIMP_ID(32'd2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .csr_re_i(csr_re), .csr_raddr_i(csr_raddr), .csr_rdata_o(csr_rdata),
        .csr_we_i(csr_we), .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata),
        .csr_illegal_o(csr_illegal),
        .instr_ret_i(instr_ret), .hpm_event_i(hpm_event),
        .trap_i(trap), .trap_irq_i(trap_irq), .trap_cause_i(trap_cause),
        .trap_pc_i(trap_pc), .trap_val_i(trap_val), .mret_i(mret),
        .irq_ext_i(irq_ext), .irq_tmr_i(irq_tmr), .irq_sw_i(irq_sw),
        .irq_pending_o(irq_pending), .trap_target_o(trap_target),
        .mret_target_o(mret_target), .priv_lvl_o(priv_lvl)
    );

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_underflow: got %h required a queued entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: got %h required %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [11:0] a, input string tag, input logic [31:0] v);
        push(tag, v);
        csr_re = 1'b1;
        csr_raddr = a;
        #1;
        pop_check(csr_rdata);
        csr_re = 1'b0;
    endtask

    task automatic rd_ill(input logic [11:0] a, input string tag);
        push({tag, "_ill"}, 32'd1);
        push({tag, "_data"}, 32'd0);
        csr_re = 1'b1;
        csr_raddr = a;
        #1;
        pop_check({31'd0, csr_illegal});
        pop_check(csr_rdata);
        csr_re = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1;
        csr_waddr = a;
        csr_wdata = d;
        @(negedge clk);
        csr_we = 1'b0;
    endtask

    task automatic chk_priv(input string tag, input logic [1:0] p);
        push(tag, {30'd0, p});
        #1;
        pop_check({30'd0, priv_lvl});
    endtask

    task automatic chk_irq(input string tag, input logic p);
        push(tag, {31'd0, p});
        #1;
        pop_check({31'd0, irq_pending});
    endtask

    initial begin
        #2000000;
        $error("FAIL watchdog: got timeout required completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1;
        csr_re = 0; csr_we = 0; csr_raddr = '0; csr_waddr = '0; csr_wdata = '0;
        instr_ret = 0; hpm_event = '0; trap = 0; trap_irq = 0; mret = 0;
        trap_cause = '0; trap_pc = '0; trap_val = '0;
        irq_ext = 0; irq_tmr = 0; irq_sw = 0;
        tick(2);
        chk_priv("rst_priv", 2'b11);
        rst = 1'b0;

        // Reset values and identity registers
        rd(12'hB00, "rst_mcycle", 32'd0);
        rd(12'h301, "misa", 32'h4000_0100);
        rd(12'hF14, "mhartid", 32'h0000_00A5);
        rd(12'hF13, "mimpid", 32'd2);
        rd(12'h300, "rst_mstatus", 32'h0000_0080);
        rd(12'h305, "rst_mtvec", 32'd0);
        rd(12'h344, "rst_mip", 32'd0);
        chk_irq("rst_irq", 1'b0);

        // mcycle counts once per clock
        tick(3);
        rd(12'hB00, "mcycle_3", 32'd3);
        rd(12'hB80, "mcycleh_0", 32'd0);

        // Low-half overflow carries into high half
        wr(12'hB80, 32'd0);
        wr(12'hB00, 32'hFFFF_FFFF);
        tick(2);
        rd(12'hB00, "mcycle_wrap", 32'd1);
        rd(12'hB80, "mcycleh_carry", 32'd1);

        // Inhibit freezes mcycle (write edge still counts)
        wr(12'h320, 32'd1);
        tick(3);
        rd(12'hB00, "mcycle_frozen", 32'd2);
        rd(12'hB80, "mcycleh_frozen", 32'd1);

        // minstret and hpm counters
        instr_ret = 1'b1;
        tick(3);
        instr_ret = 1'b0;
        rd(12'hB02, "minstret", 32'd3);
        hpm_event = 4'b0010;
        tick(2);
        hpm_event = 4'b0000;
        rd(12'hB04, "mhpmcnt4", 32'd2);
        rd(12'hB03, "mhpmcnt3", 32'd0);
        rd_ill(12'hB07, "mhpmcnt7");

        // Timer interrupt pending path
        wr(12'h304, 32'h80);
        wr(12'h300, 32'h8);
        rd(12'h300, "mstatus_mie", 32'h8);
        irq_tmr = 1'b1;
        tick(1);
        chk_irq("irq_1clk", 1'b0);
        rd(12'h344, "mip_mtip", 32'h80);
        tick(1);
        chk_irq("irq_2clk", 1'b1);
        wr(12'h304, 32'h0);
        chk_irq("irq_hold", 1'b1);
        tick(1);
        chk_irq("irq_clear", 1'b0);
        irq_tmr = 1'b0;

        // Enter U-mode via mret (mpp=U)
        wr(12'h300, 32'h0);
        mret = 1'b1;
        tick(1);
        mret = 1'b0;
        chk_priv("mret_to_u", 2'b00);

        // U-mode illegal accesses
        rd_ill(12'h300, "u_rd_mstatus");
        rd_ill(12'hC00, "u_rd_cycle");
        csr_we = 1'b1; csr_waddr = 12'hF11; csr_wdata = 32'h1;
        push("u_wr_ro_ill", 32'd1);
        #1;
        pop_check({31'd0, csr_illegal});
        csr_waddr = 12'h340; csr_wdata = 32'h5A5A;
        push("u_wr_mscratch_ill", 32'd1);
        #1;
        pop_check({31'd0, csr_illegal});
        tick(1);
        csr_we = 1'b0;

        // Trap and mret together: trap wins; pc low bits dropped
        trap = 1'b1; mret = 1'b1; trap_irq = 1'b0; trap_cause = 5'd5;
        trap_pc = 32'h107; trap_val = 32'hDEAD_BEEF;
        push("exc_target", 32'd0);
        #1;
        pop_check(trap_target);
        tick(1);
        trap = 1'b0; mret = 1'b0;
        chk_priv("trap_to_m", 2'b11);
        rd(12'h341, "mepc", 32'h104);
        rd(12'h342, "mcause", 32'd5);
        rd(12'h343, "mtval", 32'hDEAD_BEEF);
        rd(12'h300, "mstatus_trap", 32'h0);
        rd(12'h340, "mscratch_kept", 32'h0);
        rd(12'hB02, "minstret_kept", 32'd3);
        push("mret_target", 32'h104);
        #1;
        pop_check(mret_target);

        // mret back to U, trap back to M
        mret = 1'b1;
        tick(1);
        mret = 1'b0;
        chk_priv("mret2_to_u", 2'b00);
        trap = 1'b1; trap_cause = 5'd2; trap_pc = 32'h180;
        tick(1);
        trap = 1'b0;
        rd(12'h300, "mstatus_trap2", 32'h0);
        rd(12'h342, "mcause2", 32'd2);

        // Trap beats mepc write; unrelated CSR write lands alongside a trap
        trap = 1'b1; trap_cause = 5'd3; trap_pc = 32'h200;
        wr(12'h341, 32'h4444);
        rd(12'h341, "mepc_trap_prio", 32'h200);
        trap_cause = 5'd4; trap_pc = 32'h300;
        wr(12'h340, 32'h77);
        trap = 1'b0;
        rd(12'h340, "mscratch_with_trap", 32'h77);
        rd(12'h300, "mstatus_mpp_m", 32'h1800);
        mret = 1'b1;
        tick(1);
        mret = 1'b0;
        chk_priv("mret_stay_m", 2'b11);
        rd(12'h300, "mstatus_mret", 32'h80);

        // mtvec mode and trap target
        wr(12'h305, 32'h1001);
        trap_irq = 1'b1; trap_cause = 5'd7;
`ifdef CSR_VECTORED_MTVEC_EN
        rd(12'h305, "mtvec_vec", 32'h1001);
        push("irq_target", 32'h101C);
`else
        rd(12'h305, "mtvec_vec", 32'h1000);
        push("irq_target", 32'h1000);
`endif
        #1;
        pop_check(trap_target);
        trap_irq = 1'b0;
        push("exc_target_base", 32'h1000);
        #1;
        pop_check(trap_target);
        trap_cause = 5'd0;

        // Asynchronous reset mid-cycle
        #10;
        rst = 1'b1;
        #1;
        chk_priv("arst_priv", 2'b11);
        rd(12'hB00, "arst_mcycle", 32'd0);
        rd(12'h305, "arst_mtvec", 32'd0);
        rd(12'h340, "arst_mscratch", 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
